// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Lets the VGA scan-out path and a pixel writer share one single-port
//   frame-buffer RAM. Scan-out reads always win. A write is only placed on
//   a cycle that is neither a read slot nor the cycle right after one, so
//   the RAM read data is never disturbed while it is being latched. The
//   FB_W x FB_H RGB444 buffer is pixel-doubled onto the 640x480 raster.
//
// Ports
//   clk, reset               system clock, asynchronous active-low reset
//   pixel_tick, DE           pixel-advance pulse and display enable
//   x_pixel, y_pixel         current raster position from the decoder
//   wr_req/wr_addr/wr_data   writer request, held until wr_ack
//   wr_ack                   one-cycle pulse: write performed or dropped
//   wr_err, err_clr          sticky out-of-range flag and its clear
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   frame-buffer RAM port
//   r_port, g_port, b_port   colour outputs, one pixel period behind DE
//
// Write FSM
//   state | meaning
//   IDLE  | no write in progress, waiting for a usable wr_req cycle
//   WRITE | RAM write pending; issued on the first cycle clear of reads
//   ACK   | wr_ack pulse, request completed or dropped

module vga_fb_arbiter #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_tick,
  input  logic              DE,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [11:0]       wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  input  logic              err_clr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [11:0]       mem_wdata,
  input  logic [11:0]       mem_rdata,
  output logic [3:0]        r_port,
  output logic [3:0]        g_port,
  output logic [3:0]        b_port
);

  localparam logic [31:0] FB_SIZE = 32'(FB_W * FB_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              read_slot, read_slot_d, slot_busy;
  logic              addr_ok, err_set;
  logic [ADDR_W-1:0] x_half, y_half, rd_addr;
  logic [11:0]       fetch_reg, rgb;
  logic              de_prev;
  logic              unused_bits;

  // Row parity only selects the duplicated screen row, it never addresses RAM.
  assign unused_bits = y_pixel[0];

  // Gated by reset so the RAM port is quiet while reset is held.
  assign read_slot = reset & pixel_tick & DE & ~x_pixel[0];
  assign slot_busy = read_slot | read_slot_d;
  assign addr_ok   = (32'(wr_addr) < FB_SIZE);

  assign x_half = ADDR_W'(x_pixel[9:1]);
  assign y_half = ADDR_W'(y_pixel[9:1]);

  generate
    if (FB_W == 320) begin : g_addr_shift
      // 320*y = 256*y + 64*y
      assign rd_addr = (y_half << 8) + (y_half << 6) + x_half;
    end else begin : g_addr_mul
      assign rd_addr = y_half * ADDR_W'(FB_W) + x_half;
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_req && !slot_busy) begin
          state_nxt = addr_ok ? WRITE : ACK;
        end
      end
      // A read slot may land on the cycle after IDLE decided; wait it out.
      WRITE: begin
        if (!slot_busy) begin
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: the read port takes precedence over any pending write.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_ack    = (state == ACK);
    if (read_slot) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr;
    end else if (state == WRITE && !slot_busy) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end
  end

  // Dropped (out-of-range) request is the IDLE -> ACK shortcut.
  assign err_set = (state == IDLE) && (state_nxt == ACK);

  // Scan-out datapath and error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_slot_d <= 1'b0;
      fetch_reg   <= '0;
      de_prev     <= 1'b0;
      rgb         <= '0;
      wr_err      <= 1'b0;
    end else begin
      read_slot_d <= read_slot;
      if (read_slot_d) begin
        fetch_reg <= mem_rdata;
      end
      // Odd columns reuse fetch_reg, which doubles each fb pixel horizontally.
      if (pixel_tick) begin
        rgb     <= de_prev ? fetch_reg : 12'h000;
        de_prev <= DE;
      end
      if (err_set) begin
        wr_err <= 1'b1;
      end else if (err_clr) begin
        wr_err <= 1'b0;
      end
    end
  end

  assign r_port = rgb[11:8];
  assign g_port = rgb[7:4];
  assign b_port = rgb[3:0];

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

  localparam int FB_SIZE = 76800;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_tick;
  logic        DE;
  logic [9:0]  x_pixel;
  logic [9:0]  y_pixel;
  logic        wr_req;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ack;
  logic        wr_err;
  logic        err_clr;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [3:0]  r_port, g_port, b_port;

  vga_fb_arbiter #(.FB_W(320), .FB_H(240), .ADDR_W(17)) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_tick (pixel_tick),
    .DE         (DE),
    .x_pixel    (x_pixel),
    .y_pixel    (y_pixel),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .err_clr    (err_clr),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .r_port     (r_port),
    .g_port     (g_port),
    .b_port     (b_port)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          we_cnt = 0;
  int          ack_cnt = 0;
  int          en_cnt = 0;
  logic [11:0] ram    [0:FB_SIZE-1];
  logic [11:0] fb_exp [0:FB_SIZE-1];
  logic [11:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel period: tick on the first of four cycles.
  task automatic pixel(input int x, input int y, input bit de);
    int a;
    x_pixel    = 10'(x);
    y_pixel    = 10'(y);
    DE         = de;
    pixel_tick = 1'b1;
    @(posedge clk); #1;
    pixel_tick = 1'b0;
    if (exp_q.size() > 0)
      chk($sformatf("rgb x=%0d y=%0d", x, y), 32'({r_port, g_port, b_port}), 32'(exp_q.pop_front()));
    a = (y / 2) * 320 + (x / 2);
    exp_q.push_back(de ? fb_exp[a] : 12'h000);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic scan(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) pixel(x, y, 1'b1);
    pixel(0, y, 1'b0);
  endtask

  task automatic do_write(input int addr, input logic [11:0] data);
    bit got;
    got     = 1'b0;
    wr_addr = 17'(addr);
    wr_data = data;
    wr_req  = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (wr_ack) begin got = 1'b1; break; end
    end
    chk("wr_ack_seen", 32'(got), 32'd1);
    wr_req = 1'b0;
    if (got && addr < FB_SIZE) fb_exp[addr] = data;
  endtask

  // wr_req held high across back-to-back requests.
  task automatic burst(input int base, input int n);
    int last;
    bit got;
    last   = cyc;
    wr_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_addr = 17'(base + i);
      wr_data = 12'(i * 37 + 1);
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        if (wr_ack) begin got = 1'b1; break; end
      end
      chk("burst_ack", 32'(got), 32'd1);
      if (i > 0) chk($sformatf("burst_gap_le8 gap=%0d", cyc - last), 32'((cyc - last) <= 8), 32'd1);
      last = cyc;
      if (got) fb_exp[base + i] = 12'(i * 37 + 1);
    end
    wr_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    reset = 1'b0; pixel_tick = 1'b0; DE = 1'b0; x_pixel = '0; y_pixel = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; err_clr = 1'b0;
    for (int i = 0; i < FB_SIZE; i++) begin ram[i] = 12'h000; fb_exp[i] = 12'h000; end

    // RAM model and per-cycle bus checks
    fork
      begin : monitor
        bit          slot_now, slot_prev;
        logic        c_en, c_we;
        logic [16:0] c_addr;
        logic [11:0] c_wd;
        logic [16:0] rd_a;
        slot_prev = 1'b0;
        forever begin
          @(negedge clk);
          slot_now = pixel_tick && DE && !x_pixel[0] && reset;
          rd_a = 17'((int'(y_pixel) / 2) * 320 + int'(x_pixel) / 2);
          if (slot_now)
            chk("rd_slot_bus", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, rd_a}));
          if (mem_we) begin
            we_cnt++;
            chk("we_clear_of_slot", 32'(slot_now || slot_prev), 32'd0);
          end
          if (!mem_en) chk("bus_idle_zero", 32'({mem_addr, mem_wdata}), 32'd0);
          if (wr_ack) ack_cnt++;
          if (mem_en) en_cnt++;
          slot_prev = slot_now;
          c_en = mem_en; c_we = mem_we; c_addr = mem_addr; c_wd = mem_wdata;
          @(posedge clk);
          cyc++;
          if (c_en && c_addr < 17'(FB_SIZE)) begin
            if (c_we) ram[c_addr] = c_wd;
            else mem_rdata <= ram[c_addr];
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'({wr_ack, wr_err, mem_en, mem_we, r_port, g_port, b_port}), 32'd0);
    chk("rst_bus", 32'({mem_addr, mem_wdata}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.push_back(12'h000);

    // Blank buffer scanned: black output, no write activity
    scan(0, 0, 639);
    scan(479, 600, 639);
    chk("t1_no_we", 32'(we_cnt), 32'd0);
    chk("t1_no_ack", 32'(ack_cnt), 32'd0);

    // Corner writes during blanking, then scan the corners
    do_write(0, 12'hF00);
    chk("t2_no_err", 32'(wr_err), 32'd0);
    do_write(76799, 12'h00F);
    chk("t2_ram0", 32'(ram[0]), 32'h0F00);
    chk("t2_ram_last", 32'(ram[76799]), 32'h000F);
    scan(0, 0, 3);
    scan(1, 0, 3);
    scan(478, 636, 639);
    scan(479, 636, 639);

    // Out-of-range write dropped, error flag sticky, set beats clear
    en_cnt = 0;
    do_write(76800, 12'h123);
    chk("t4_err_set", 32'(wr_err), 32'd1);
    chk("t4_no_mem_en", 32'(en_cnt), 32'd0);
    @(posedge clk); #1;
    chk("t4_err_sticky", 32'(wr_err), 32'd1);
    err_clr = 1'b1;
    do_write(90000, 12'h777);
    chk("t4_set_wins", 32'(wr_err), 32'd1);
    @(posedge clk); #1;
    chk("t4_err_clr", 32'(wr_err), 32'd0);
    err_clr = 1'b0;
    do_write(5, 12'h0F0);
    chk("t4_good_no_err", 32'(wr_err), 32'd0);

    // Horizontal doubling around fb addr 1
    do_write(1, 12'hABC);
    do_write(2, 12'h123);
    scan(0, 0, 5);

    // Writes contending with active scan-out
    for (int i = 0; i < 32; i++) do_write(320 + i, 12'(i * 97 + 5));
    fork
      scan(2, 0, 63);
      burst(50000, 20);
    join
    for (int i = 0; i < 20; i++)
      chk($sformatf("t3_ram %0d", 50000 + i), 32'(ram[50000 + i]), 32'(fb_exp[50000 + i]));

    // Reset in the middle of a write
    pixel(0, 0, 1'b1);
    pixel(1, 0, 1'b1);
    DE = 1'b0;
    wr_addr = 17'd1000; wr_data = 12'h5A5; wr_req = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (mem_we) begin got = 1'b1; break; end
    end
    chk("t5_reach_write", 32'(got), 32'd1);
    reset = 1'b0;
    #1;
    chk("t5_rst_outs", 32'({mem_en, mem_we, wr_ack, r_port, g_port, b_port}), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("t5_no_ack_in_rst", 32'(wr_ack), 32'd0);
    end
    chk("t5_write_abandoned", 32'(ram[1000]), 32'h0000);
    reset = 1'b1;
    exp_q.delete();
    exp_q.push_back(12'h000);
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (wr_ack) begin got = 1'b1; break; end
    end
    chk("t5_reissue_ack", 32'(got), 32'd1);
    wr_req = 1'b0;
    fb_exp[1000] = 12'h5A5;
    chk("t5_reissue_ram", 32'(ram[1000]), 32'h05A5);
    scan(6, 0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
